// File: rtl/kf8259_inta_master.sv
// CPU-side INTA sequencer for the KF8259: synchronizes INT, generates the
// 2-pulse (8086) or 3-pulse (8080) INTA_N train and returns the captured vector.
module kf8259_inta_master #(
    parameter int unsigned PULSE_WIDTH = 4,
    parameter int unsigned GAP_WIDTH   = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        interrupt,
    input  logic        enable,
    input  logic        mode_8086,
    input  logic [7:0]  data_bus_in,
    output logic        interrupt_acknowledge_n,
    output logic        vector_valid,
    input  logic        vector_ready,
    output logic [7:0]  vector,
    output logic [15:0] call_address,
    output logic        opcode_error,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        GAP,
        VALID,
        RECOVER
    } state_t;

    localparam logic [3:0] LOW_LOAD = 4'(PULSE_WIDTH - 1);
    localparam logic [3:0] GAP_LOAD = 4'(GAP_WIDTH - 1);
    // RECOVER plus the following IDLE cycle keep INTA_N high for GAP_WIDTH+2
    // cycles after the handshake edge before the next possible fall.
    localparam logic [3:0] REC_LOAD = 4'(GAP_WIDTH);
    localparam logic [7:0] CALL_OPCODE = 8'hCD;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  pulse_q, pulse_d;
    logic        mode_q, mode_d;
    logic        inta_n_q, inta_n_d;
    logic        valid_q, valid_d;
    logic [7:0]  vector_q, vector_d;
    logic [15:0] call_q, call_d;
    logic        operr_q, operr_d;
    logic        busy_q, busy_d;
    logic        sync1_q, sync2_q;
    logic        int_sync;
    logic        last_pulse;

    assign int_sync   = sync2_q;
    assign last_pulse = mode_q ? (pulse_q == 2'd2) : (pulse_q == 2'd3);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= interrupt;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pulse_q  <= '0;
            mode_q   <= 1'b0;
            inta_n_q <= 1'b1;
            valid_q  <= 1'b0;
            vector_q <= '0;
            call_q   <= '0;
            operr_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
            mode_q   <= mode_d;
            inta_n_q <= inta_n_d;
            valid_q  <= valid_d;
            vector_q <= vector_d;
            call_q   <= call_d;
            operr_q  <= operr_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pulse_d  = pulse_q;
        mode_d   = mode_q;
        inta_n_d = inta_n_q;
        valid_d  = valid_q;
        vector_d = vector_q;
        call_d   = call_q;
        operr_d  = operr_q;

        case (state_q)
            IDLE: begin
                if (int_sync && enable) begin
                    state_d  = LOW;
                    cnt_d    = LOW_LOAD;
                    pulse_d  = 2'd1;
                    mode_d   = mode_8086;
                    inta_n_d = 1'b0;
                    vector_d = '0;
                    call_d   = '0;
                    operr_d  = 1'b0;
                end
            end
            LOW: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    inta_n_d = 1'b1;
                    case (pulse_q)
                        2'd1: begin
                            if (!mode_q && (data_bus_in != CALL_OPCODE)) begin
                                operr_d = 1'b1;
                            end
                        end
                        2'd2: begin
                            vector_d = data_bus_in;
                            if (!mode_q) begin
                                call_d[7:0] = data_bus_in;
                            end
                        end
                        2'd3: call_d[15:8] = data_bus_in;
                        default: ;
                    endcase
                    if (last_pulse) begin
                        state_d = VALID;
                        valid_d = 1'b1;
                    end else begin
                        state_d = GAP;
                        cnt_d   = GAP_LOAD;
                    end
                end
            end
            GAP: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d  = LOW;
                    cnt_d    = LOW_LOAD;
                    pulse_d  = pulse_q + 2'd1;
                    inta_n_d = 1'b0;
                end
            end
            VALID: begin
                if (vector_ready) begin
                    state_d = RECOVER;
                    valid_d = 1'b0;
                    cnt_d   = REC_LOAD;
                end
            end
            RECOVER: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                inta_n_d = 1'b1;
                valid_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign interrupt_acknowledge_n = inta_n_q;
    assign vector_valid            = valid_q;
    assign vector                  = vector_q;
    assign call_address            = call_q;
    assign opcode_error            = operr_q;
    assign busy                    = busy_q;

endmodule

// File: tb/tb_kf8259_inta_master.sv
// Bench for kf8259_inta_master: timing of every edge is predicted from the
// pulse-train formulas and compared against the DUT outputs.
module tb_kf8259_inta_master;

    localparam int P = 4;
    localparam int G = 2;

    logic        clock;
    logic        reset_n;
    logic        interrupt;
    logic        enable;
    logic        mode_8086;
    logic [7:0]  data_bus_in;
    logic        interrupt_acknowledge_n;
    logic        vector_valid;
    logic        vector_ready;
    logic [7:0]  vector;
    logic [15:0] call_address;
    logic        opcode_error;
    logic        busy;

    int total;
    int bad;

    kf8259_inta_master #(
        .PULSE_WIDTH(P),
        .GAP_WIDTH  (G)
    ) dut (
        .clock                  (clock),
        .reset_n                (reset_n),
        .interrupt              (interrupt),
        .enable                 (enable),
        .mode_8086              (mode_8086),
        .data_bus_in            (data_bus_in),
        .interrupt_acknowledge_n(interrupt_acknowledge_n),
        .vector_valid           (vector_valid),
        .vector_ready           (vector_ready),
        .vector                 (vector),
        .call_address           (call_address),
        .opcode_error           (opcode_error),
        .busy                   (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic test_reset();
        @(negedge clock);
        total++;
        if ({interrupt_acknowledge_n, vector_valid, vector, call_address, opcode_error, busy}
            !== {1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_values got inta=%b valid=%b vec=%h call=%h err=%b busy=%b",
                     interrupt_acknowledge_n, vector_valid, vector, call_address, opcode_error, busy);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            total++;
            if (interrupt_acknowledge_n !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL idle_after_reset got inta=%b busy=%b required inta=1 busy=0",
                         interrupt_acknowledge_n, busy);
            end
        end
    endtask

    task automatic test_enable_gate();
        enable    = 1'b0;
        interrupt = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            total++;
            if (interrupt_acknowledge_n !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL enable_gate cyc=%0d got inta=%b busy=%b required inta=1 busy=0",
                         i, interrupt_acknowledge_n, busy);
            end
        end
        interrupt = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    // Runs one complete acknowledge sequence. Edge 0 is the first rising edge
    // after INT is raised; the start edge k is therefore edge 2.
    task automatic test_sequence(input string name, input bit m86,
                                 input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                                 input int ready_wait, input bit drop_mid, input bit hold_int);
        int np, k, vrise, h, last, f;
        logic [15:0] exp_call;
        logic        exp_err, exp_low, exp_valid, exp_busy;
        k        = 2;
        np       = m86 ? 2 : 3;
        vrise    = k + np * P + (np - 1) * G;
        h        = vrise + ready_wait + 1;
        last     = h + G + 2;
        exp_call = m86 ? 16'h0000 : {b3, b2};
        exp_err  = !m86 && (b1 != 8'hCD);
        for (int e = 0; e <= last; e++) begin
            if (e == 0) begin
                interrupt = 1'b1;
                enable    = 1'b1;
                mode_8086 = m86;
            end
            if (e == k + 1) begin
                mode_8086 = !m86;
                if (!hold_int && !drop_mid) interrupt = 1'b0;
            end
            if (drop_mid && e == k + 2) begin
                interrupt = 1'b0;
                enable    = 1'b0;
            end
            vector_ready = (ready_wait == 0) ? 1'b1 : (e >= h);
            data_bus_in  = 8'($urandom);
            for (int n = 1; n <= np; n++) begin
                f = k + (n - 1) * (P + G);
                if (e - 1 >= f && e - 1 < f + P)
                    data_bus_in = (n == 1) ? b1 : (n == 2) ? b2 : b3;
            end

            @(negedge clock);

            exp_low = 1'b0;
            for (int n = 1; n <= np; n++) begin
                f = k + (n - 1) * (P + G);
                if (e >= f && e < f + P) exp_low = 1'b1;
            end
            if (hold_int && e == last) exp_low = 1'b1;
            exp_valid = (e >= vrise) && (e < h);
            exp_busy  = ((e >= k) && (e <= h + G)) || (hold_int && e == last);

            total++;
            if (interrupt_acknowledge_n !== !exp_low) begin
                bad++;
                $display("FAIL %s inta edge=%0d got=%b required=%b", name, e,
                         interrupt_acknowledge_n, !exp_low);
            end
            total++;
            if (vector_valid !== exp_valid) begin
                bad++;
                $display("FAIL %s valid edge=%0d got=%b required=%b", name, e, vector_valid, exp_valid);
            end
            total++;
            if (busy !== exp_busy) begin
                bad++;
                $display("FAIL %s busy edge=%0d got=%b required=%b", name, e, busy, exp_busy);
            end
            if (e == k) begin
                total++;
                if ({vector, call_address, opcode_error} !== 25'h0) begin
                    bad++;
                    $display("FAIL %s cleared_at_start got vec=%h call=%h err=%b required all zero",
                             name, vector, call_address, opcode_error);
                end
            end
            if (e >= vrise && !(hold_int && e == last)) begin
                total++;
                if (vector !== b2 || call_address !== exp_call || opcode_error !== exp_err) begin
                    bad++;
                    $display("FAIL %s result edge=%0d got vec=%h call=%h err=%b required vec=%h call=%h err=%b",
                             name, e, vector, call_address, opcode_error, b2, exp_call, exp_err);
                end
            end
        end
        vector_ready = 1'b0;
        if (hold_int) begin
            interrupt = 1'b0;
            reset_n   = 1'b0;
            repeat (2) @(negedge clock);
            reset_n = 1'b1;
            repeat (2) @(negedge clock);
        end
    endtask

    task automatic test_8086();
        test_sequence("m8086_48", 1'b1, 8'hFF, 8'h48, 8'h00, 0, 1'b0, 1'b0);
    endtask

    task automatic test_8080();
        test_sequence("m8080_call", 1'b0, 8'hCD, 8'h20, 8'h01, 0, 1'b0, 1'b0);
    endtask

    task automatic test_opcode_error();
        test_sequence("m8080_operr", 1'b0, 8'h00, 8'h33, 8'h44, 0, 1'b0, 1'b0);
    endtask

    task automatic test_drop_mid();
        test_sequence("drop_mid", 1'b1, 8'h12, 8'h5A, 8'h00, 5, 1'b1, 1'b0);
        test_sequence("drop_mid80", 1'b0, 8'hCD, 8'hA5, 8'h3C, 5, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        test_sequence("held_int", 1'b1, 8'h00, 8'h77, 8'h00, 0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        bit          m;
        logic [7:0]  b1;
        for (int i = 0; i < 6; i++) begin
            m  = 1'($urandom_range(0, 1));
            b1 = ($urandom_range(0, 1) == 1) ? 8'hCD : 8'($urandom);
            test_sequence("random", m, b1, 8'($urandom), 8'($urandom),
                          int'($urandom_range(0, 3)), 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        int waited;
        interrupt = 1'b1;
        enable    = 1'b1;
        waited    = 0;
        while (interrupt_acknowledge_n !== 1'b0 && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        total++;
        if (interrupt_acknowledge_n !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_start got inta=%b required=0 within 20 cycles",
                     interrupt_acknowledge_n);
        end
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({interrupt_acknowledge_n, vector_valid, vector, call_address, opcode_error, busy}
            !== {1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid_async got inta=%b valid=%b vec=%h call=%h err=%b busy=%b",
                     interrupt_acknowledge_n, vector_valid, vector, call_address, opcode_error, busy);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(negedge clock);
            total++;
            if (interrupt_acknowledge_n !== (e < 3)) begin
                bad++;
                $display("FAIL reset_restart edge=%0d got inta=%b required=%b",
                         e, interrupt_acknowledge_n, (e < 3));
            end
        end
        interrupt = 1'b0;
        reset_n   = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        reset_n      = 1'b0;
        interrupt    = 1'b0;
        enable       = 1'b0;
        mode_8086    = 1'b1;
        data_bus_in  = 8'h00;
        vector_ready = 1'b0;
        test_reset();
        test_enable_gate();
        test_8086();
        test_8080();
        test_opcode_error();
        test_drop_mid();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
